// File: rtl/fifo_pkg.sv
// Shared types and constants for the async-FIFO read-side stream consumer.
package fifo_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_BURST_LEN  = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Width of the in-burst pop counter; BURST_LEN is at least 2, so this is at least 1.
    function automatic int pop_cnt_width(input int burst_len);
        return $clog2(burst_len);
    endfunction

endpackage

// File: rtl/stream_skid_buf.sv
// Two-entry valid/ready buffer: output register plus one skid register.
// Upstream must not offer a word while skid_valid is high.
module stream_skid_buf #(
    parameter int WIDTH = 33
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             skid_valid
);

    logic             out_valid_reg;
    logic [WIDTH-1:0] out_data_reg;
    logic             skid_valid_reg;
    logic [WIDTH-1:0] skid_data_reg;
    logic             out_free;

    // The output register can take a word when empty or being consumed this cycle.
    assign out_free = !out_valid_reg || out_ready;

    always_ff @(posedge clk) begin
        if (srst) begin
            out_valid_reg  <= 1'b0;
            out_data_reg   <= '0;
            skid_valid_reg <= 1'b0;
            skid_data_reg  <= '0;
        end else if (out_free) begin
            if (skid_valid_reg) begin
                out_valid_reg  <= 1'b1;
                out_data_reg   <= skid_data_reg;
                skid_valid_reg <= in_valid;
                if (in_valid) begin
                    skid_data_reg <= in_data;
                end
            end else begin
                out_valid_reg <= in_valid;
                if (in_valid) begin
                    out_data_reg <= in_data;
                end
            end
        end else if (in_valid) begin
            skid_valid_reg <= 1'b1;
            skid_data_reg  <= in_data;
        end
    end

    assign out_valid  = out_valid_reg;
    assign out_data   = out_data_reg;
    assign skid_valid = skid_valid_reg;

endmodule

// File: rtl/fifo_rd_stream.sv
// Drains a first-word-fall-through FIFO read port into a valid/ready stream,
// framing words into fixed-length bursts that are never truncated by en.
module fifo_rd_stream
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int BURST_LEN  = DEFAULT_BURST_LEN,
    parameter int BCNT_WIDTH = 16
) (
    input  logic                  rclk,
    input  logic                  rrst,
    input  logic                  en,
    input  logic                  fifo_rempty,
    input  logic [DATA_WIDTH-1:0] fifo_rdata,
    output logic                  fifo_rinc,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic                  busy,
    output logic [BCNT_WIDTH-1:0] burst_cnt
);

    localparam int PCW = pop_cnt_width(BURST_LEN);
    localparam logic [PCW-1:0] LAST_BEAT = PCW'(BURST_LEN - 1);

    state_t                state_reg;
    logic [PCW-1:0]        pop_cnt_reg;
    logic [BCNT_WIDTH-1:0] burst_cnt_reg;
    logic                  skid_valid;
    logic                  pop_ok;
    logic                  pop_last;
    logic [DATA_WIDTH:0]   out_word;

    // Draining only continues while a burst is open, so the stream stops on a boundary.
    assign pop_ok    = (state_reg == ST_RUN) || ((state_reg == ST_DRAIN) && (pop_cnt_reg != '0));
    assign fifo_rinc = pop_ok && !fifo_rempty && !skid_valid && !rrst;
    assign pop_last  = (pop_cnt_reg == LAST_BEAT);

    stream_skid_buf #(
        .WIDTH (DATA_WIDTH + 1)
    ) u_skid (
        .clk        (rclk),
        .srst       (rrst),
        .in_valid   (fifo_rinc),
        .in_data    ({pop_last, fifo_rdata}),
        .out_ready  (m_ready),
        .out_valid  (m_valid),
        .out_data   (out_word),
        .skid_valid (skid_valid)
    );

    assign m_last = out_word[DATA_WIDTH];
    assign m_data = out_word[DATA_WIDTH-1:0];

    always_ff @(posedge rclk) begin
        if (rrst) begin
            state_reg     <= ST_IDLE;
            pop_cnt_reg   <= '0;
            burst_cnt_reg <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (en) state_reg <= ST_RUN;
                end
                ST_RUN: begin
                    if (!en) state_reg <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (en) begin
                        state_reg <= ST_RUN;
                    end else if ((pop_cnt_reg == '0) && !m_valid && !skid_valid) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase

            if (fifo_rinc) begin
                pop_cnt_reg <= pop_last ? '0 : pop_cnt_reg + PCW'(1);
            end

            if (m_valid && m_ready && m_last) begin
                burst_cnt_reg <= burst_cnt_reg + BCNT_WIDTH'(1);
            end
        end
    end

    assign busy      = (state_reg != ST_IDLE) || m_valid || skid_valid;
    assign burst_cnt = burst_cnt_reg;

endmodule

// File: doc/fifo_rd_stream.md
Name: fifo_rd_stream

Overview:
- Read-side consumer for the team's async FIFO; lives entirely in the read clock domain.
- Drains the FIFO read port (rempty/rinc/rdata, first-word-fall-through) into a valid/ready stream.
- Packs words into fixed-length bursts with an end-of-burst marker.
- Enable/disable always stops on a burst boundary, so downstream never sees a truncated burst.

Parameters:
- DATA_WIDTH, 32, width of FIFO words and stream data.
- BURST_LEN, 8, words per burst; legal range 2..65535.
- BCNT_WIDTH, 16, width of the completed-burst counter.

Ports:
- rclk  input  1  read-domain clock; all logic on rising edge.
- rrst  input  1  synchronous active-high reset, sampled on rclk.
- en  input  1  stream enable, level-sensitive.
- fifo_rempty  input  1  FIFO empty flag (read domain).
- fifo_rdata  input  DATA_WIDTH  FIFO head word; valid whenever fifo_rempty=0.
- fifo_rinc  output  1  pop strobe to the FIFO; combinational.
- m_valid  output  1  stream data valid.
- m_ready  input  1  stream sink ready.
- m_data  output  DATA_WIDTH  stream data.
- m_last  output  1  high on the final word of each burst.
- busy  output  1  state != IDLE or any buffered word pending.
- burst_cnt  output  BCNT_WIDTH  completed bursts; increments on a handshake with m_last=1; wraps.

Behaviour:
- Reset (rrst=1 at a rclk edge):
  - state=IDLE; pop_cnt=0; skid emptied.
  - m_valid=0, m_data=0, m_last=0, busy=0, burst_cnt=0.
  - fifo_rinc=0 while rrst=1.
  - Reset mid-burst discards buffered words. No further pops that cycle.
- States:
  - IDLE: no pops. en=1 -> RUN.
  - RUN: pops freely; bursts are back-to-back. en=0 -> DRAIN.
  - DRAIN: pops only while pop_cnt != 0. en=1 -> RUN. When pop_cnt==0 and m_valid=0 and skid empty -> IDLE.
- Pop logic:
  - pop_ok = (RUN) or (DRAIN and pop_cnt != 0).
  - fifo_rinc = pop_ok and !fifo_rempty and !skid_valid and !rrst.
- pop_cnt:
  - Counts words popped in the current burst; range 0..BURST_LEN-1.
  - Increments on each pop; wraps to 0 on the pop where pop_cnt==BURST_LEN-1.
  - That pop's word is tagged last=1. The tag travels with the data through the buffer.
- en deasserted exactly at a burst boundary (pop_cnt==0): no further pops; buffered words still emit.
- Buffer (two entries: output register + skid register):
  - A popped word goes to the output register if it is empty or being consumed this cycle (m_valid and m_ready); otherwise it goes to the skid register.
  - On consumption with skid full, skid moves to the output register the same edge.
  - m_data/m_last hold stable while m_valid=1 and m_ready=0.
- Latency:
  - fifo_rinc at cycle N -> m_valid=1 at N+1.
  - Sustained throughput is 1 word/cycle when m_ready=1 and the FIFO is non-empty.
- FIFO empty mid-burst: pops pause. m_valid may drop between words. The burst stays open, with no timeout.
- burst_cnt increments when m_valid and m_ready and m_last; wraps from all-ones to 0.
- Simultaneous events:
  - Consumption of the output register and a new pop in one cycle: new word loads the output register; skid unaffected.
  - en falling in the same cycle as the pop that closes a burst: pop_cnt becomes 0; DRAIN pops nothing more.
- busy = (state != IDLE) or m_valid or skid_valid.

Decomposition:
- Shared package fifo_pkg:
  - State enum (IDLE/RUN/DRAIN).
  - Default DATA_WIDTH/BURST_LEN constants.
  - Function computing pop_cnt width = clog2(BURST_LEN).
- One natural sub-module, stream_skid_buf: the two-entry valid/ready register pair carrying {last, data}. The top keeps the FSM, pop_cnt and burst_cnt.

Test Plan:
- Reset then en=1, FIFO preloaded with 16 words 0..15, m_ready=1 -> fifo_rinc high 16 cycles; m_data 0..15 on consecutive cycles starting 1 cycle later; m_last on words 7 and 15; burst_cnt=2.
- m_ready held 0 with FIFO holding 5 words -> exactly 2 pops, then fifo_rinc=0; m_data=0 held stable. Release m_ready -> words 0,1,2,3,4 in order, none lost or duplicated.
- en dropped after 3 words popped -> exactly 5 more pops; stream ends on word 7 with m_last=1; state reaches IDLE; busy=0; FIFO retains remaining words.
- FIFO empty after word 4 for 10 cycles, then refilled -> no m_last until word 7; burst_cnt increments once.
- rrst asserted mid-burst with skid full -> next cycle m_valid=0, busy=0, burst_cnt=0, pop_cnt=0. After release with en=1, next popped word is tagged as beat 0.
- burst_cnt preset by running 2^BCNT_WIDTH bursts with BCNT_WIDTH=4 (16 bursts) -> wraps to 0.
